// File: rtl/byte_fetch_unit.sv
// byte_fetch_unit: prefetches 32-bit words into a byte queue and hands the MBR one byte per FETCH.
// Optional build macro BYTE_FETCH_PC_OUT_EN adds pc_cur, the byte address of the byte on byte_out.
module byte_fetch_unit #(
    parameter int unsigned QDEPTH = 8,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic              stall,
    output logic              mem_rd,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
`ifdef BYTE_FETCH_PC_OUT_EN
    ,
    output logic [ADDR_W-1:0] pc_cur
`endif
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WA = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t state;

    logic [7:0]    q [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [WA-1:0] fetch_pc;
    logic [1:0]    skip;
    logic          pending;

    logic [7:0]    word_byte [4];
    logic          wr_en;
    logic          take_fetch;
    logic          pop;
    logic          bypass;
    logic          serve;
    logic [2:0]    wr_first;
    logic [2:0]    wr_cnt;
    logic [7:0]    next_byte;

    assign stall = pending;

    // A pending fetch on an empty queue takes its byte straight from the landing word,
    // so the byte appears the cycle after the ack; that byte is then not written.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            word_byte[k] = mem_rdata[31 - 8*k -: 8];
        end
        wr_en      = (state == REQ) && mem_ack && !pc_load;
        take_fetch = fetch && !pending;
        pop        = !pc_load && (count != '0) && (pending || take_fetch);
        bypass     = pending && wr_en && (count == '0);
        serve      = pop || bypass;
        wr_first   = {1'b0, skip} + {2'b00, bypass};
        wr_cnt     = 3'd4 - wr_first;
        next_byte  = pop ? q[rd_ptr] : word_byte[skip];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (3'(k) >= wr_first) begin
                    q[wr_ptr + PW'(3'(k) - wr_first)] <= word_byte[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_pc   <= '0;
            skip       <= '0;
            pending    <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
        end else begin
            if (serve) begin
                byte_out <= next_byte;
            end
            byte_valid <= serve;

            if (pc_load) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= pc_in[ADDR_W-1:2];
                skip     <= pc_in[1:0];
                pending  <= fetch;
            end else begin
                rd_ptr <= rd_ptr + PW'(pop);
                if (wr_en) begin
                    wr_ptr   <= wr_ptr + PW'(wr_cnt);
                    fetch_pc <= fetch_pc + WA'(1);
                    skip     <= '0;
                end
                count   <= count - CW'(pop) + (wr_en ? CW'(wr_cnt) : '0);
                pending <= (pending || fetch) && !serve;
            end

            // An issued read cannot be withdrawn; a flush during REQ waits out the ack in DROP.
            case (state)
                IDLE: begin
                    if (!pc_load && (count <= CW'(QDEPTH - 4))) begin
                        state    <= REQ;
                        mem_rd   <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                    end else if (pc_load) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

`ifdef BYTE_FETCH_PC_OUT_EN
    logic [ADDR_W-1:0] next_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_cur  <= '0;
            next_pc <= '0;
        end else if (pc_load) begin
            pc_cur  <= pc_in;
            next_pc <= pc_in;
        end else if (serve) begin
            pc_cur  <= next_pc;
            next_pc <= next_pc + ADDR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_byte_fetch_unit.sv
// Bench for byte_fetch_unit: directed scenarios plus random fetch/pc_load/ack-latency traffic,
// checked against a byte-address stream model and a word-request model.
`timescale 1ns/1ps
module tb_byte_fetch_unit;
    localparam int unsigned QDEPTH = 8;
    localparam int unsigned ADDR_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        fetch;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        stall;
    logic        mem_rd;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef BYTE_FETCH_PC_OUT_EN
    logic [31:0] pc_cur;
`endif

    always #5 clk = ~clk;

    byte_fetch_unit #(.QDEPTH(QDEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .fetch      (fetch),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .stall      (stall),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef BYTE_FETCH_PC_OUT_EN
        ,
        .pc_cur     (pc_cur)
`endif
    );

    a_no_fetch_while_stall: assert property (@(posedge clk) disable iff (!reset) !(fetch && stall))
        else $error("FAIL fetch_while_stall: fetch=1 observed with stall=1");

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Stream model: address of the next byte the MBR should receive.
    logic [31:0] exp_addr;
    bit          outstanding;
    int          wait_cnt;
    // Memory model: request in flight and the word address the next request must carry.
    bit          busy;
    bit          drop;
    int          lat_cnt;
    int          lat_min;
    int          lat_max;
    logic [29:0] cur_addr;
    logic [29:0] req_exp;
    bit          good_ack;
    logic [7:0]  got_q [$];
    logic [29:0] reqs [$];
    // Inputs as the DUT saw them at the last edge.
    logic        p_load;
    logic [31:0] p_in;
    logic        p_fetch;
    logic        p_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        if (wa == 30'h40) return 32'hCAFEBABE;
        return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a[31:2]);
        case (a[1:0])
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    task automatic tick();
        p_load  = pc_load;
        p_in    = pc_in;
        p_fetch = fetch;
        p_ack   = mem_ack;
        @(posedge clk);
        #1;
        pc_load  = 1'b0;
        fetch    = 1'b0;
        good_ack = 1'b0;

        if (p_load) begin
            check("bv_after_load", byte_valid, 0);
`ifdef BYTE_FETCH_PC_OUT_EN
            check("pc_cur_load", pc_cur, p_in);
`endif
            exp_addr    = p_in;
            outstanding = p_fetch;
            wait_cnt    = 0;
        end else begin
            if (p_fetch) outstanding = 1'b1;
            if (byte_valid) begin
                check("bv_expected", outstanding, 1);
                check("byte", byte_out, mem_byte(exp_addr));
`ifdef BYTE_FETCH_PC_OUT_EN
                check("pc_cur", pc_cur, exp_addr);
`endif
                got_q.push_back(byte_out);
                exp_addr    = exp_addr + 1;
                outstanding = 1'b0;
            end
        end
        check("stall", stall, outstanding);
        wait_cnt = outstanding ? wait_cnt + 1 : 0;
        if (wait_cnt > 200) begin
            check("stall_timeout", wait_cnt, 0);
            wait_cnt = 0;
        end

        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (p_ack && busy) begin
            if (!drop && !p_load) begin
                req_exp  = req_exp + 1;
                good_ack = 1'b1;
            end
            busy = 1'b0;
            drop = 1'b0;
        end
        if (p_load) begin
            req_exp = p_in[31:2];
            if (busy) drop = 1'b1;
        end
        if (busy) check("mem_rd_held", mem_rd, 1);
        if (!busy && mem_rd) begin
            check("mem_addr", mem_addr, req_exp);
            reqs.push_back(mem_addr);
            busy     = 1'b1;
            cur_addr = mem_addr;
            lat_cnt  = $urandom_range(lat_max, lat_min);
        end
        if (busy) begin
            if (lat_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(cur_addr);
            end else begin
                lat_cnt--;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fetch_bytes(input int n);
        int issued = 0;
        int t = 0;
        int start = got_q.size();
        while ((issued < n || outstanding) && t < 400) begin
            if (issued < n && !stall && !outstanding) begin
                fetch = 1'b1;
                issued++;
            end
            tick();
            t++;
        end
        check("deliveries", got_q.size() - start, n);
    endtask

    task automatic load_pc(input logic [31:0] a);
        pc_load = 1'b1;
        pc_in   = a;
        tick();
        reqs.delete();
        got_q.delete();
    endtask

    initial begin
        int  t;
        bit  seen;
        bit  stall_ok;
        int  r;

        reset = 1'b0; pc_load = 1'b0; pc_in = '0; fetch = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        exp_addr = '0; outstanding = 0; wait_cnt = 0; busy = 0; drop = 0;
        req_exp = '0; lat_cnt = 0; lat_min = 1; lat_max = 1;
        #2;
        check("rst_byte_out", byte_out, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
`ifdef BYTE_FETCH_PC_OUT_EN
        check("rst_pc_cur", pc_cur, 0);
`endif
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        idle(20);

        // Aligned word, big-endian order, two consecutive word requests.
        load_pc(32'h100);
        idle(12);
        fetch_bytes(4);
        check("t1_b0", got_q[0], 8'hCA);
        check("t1_b1", got_q[1], 8'hFE);
        check("t1_b2", got_q[2], 8'hBA);
        check("t1_b3", got_q[3], 8'hBE);
        check("t1_req0", reqs[0], 30'h40);
        check("t1_req1", reqs[1], 30'h41);

        // Unaligned start skips the leading bytes of the first word.
        idle(20);
        load_pc(32'h102);
        idle(12);
        fetch_bytes(3);
        check("t2_b0", got_q[0], 8'hBA);
        check("t2_b1", got_q[1], 8'hBE);
        check("t2_b2", got_q[2], mem_byte(32'h104));

        // Fetch on an empty queue with 3-cycle memory: byte lands the cycle after the ack.
        idle(20);
        lat_min = 3; lat_max = 3;
        load_pc(32'h100);
        fetch = 1'b1;
        seen = 0; stall_ok = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (byte_valid) begin
                seen = 1;
                check("t3_bv_after_ack", good_ack, 1);
            end else if (!stall) begin
                stall_ok = 0;
            end
        end
        check("t3_stall_until_land", stall_ok, 1);
        check("t3_delivered", seen, 1);
        check("t3_byte", got_q[0], 8'hCA);
        idle(6);
        check("t3_no_spurious", got_q.size(), 1);

        // Flush while the request for word 0x40 is outstanding.
        idle(20);
        lat_min = 5; lat_max = 5;
        load_pc(32'h100);
        tick();
        check("t4_req_rd", mem_rd, 1);
        check("t4_req_addr", mem_addr, 30'h40);
        pc_load = 1'b1; pc_in = 32'h200; fetch = 1'b1;
        tick();
        reqs.delete();
        got_q.delete();
        t = 0;
        while (got_q.size() == 0 && t < 40) begin tick(); t++; end
        check("t4_first_byte", got_q[0], mem_byte(32'h200));
        check("t4_next_req", reqs[0], 30'h80);

        // Back-to-back fetches against single-cycle memory.
        idle(20);
        lat_min = 0; lat_max = 0;
        load_pc(32'h0);
        fetch_bytes(16);
        for (int i = 0; i < 16; i++) check("t5_seq", got_q[i], mem_byte(i));

        // Reset in the middle of a request, then a late ack while idle.
        idle(20);
        lat_min = 3; lat_max = 3;
        load_pc(32'h300);
        t = 0;
        while (!busy && t < 20) begin tick(); t++; end
        check("t6_in_req", mem_rd, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_byte_out", byte_out, 0);
        check("t6_rst_byte_valid", byte_valid, 0);
        check("t6_rst_stall", stall, 0);
        check("t6_rst_mem_rd", mem_rd, 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        mem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        exp_addr = '0; outstanding = 0; wait_cnt = 0; busy = 0; drop = 0; req_exp = '0;
        lat_min = 1; lat_max = 1;
        tick();
        check("t6_late_ack_ignored", byte_valid, 0);
        idle(12);
        got_q.delete();
        fetch_bytes(4);
        check("t6_pc0_b0", got_q[0], mem_byte(32'h0));
        check("t6_pc0_b3", got_q[3], mem_byte(32'h3));

        // Random traffic.
        lat_min = 0; lat_max = 4;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(99);
            if (r < 3) begin
                pc_load = 1'b1;
                case ($urandom_range(3))
                    0:       pc_in = 32'hFFFF_FFF0 + $urandom_range(15);
                    1:       pc_in = $urandom_range(255);
                    default: pc_in = $urandom;
                endcase
            end
            if (!stall && !outstanding && $urandom_range(99) < 60) fetch = 1'b1;
            tick();
        end
        t = 0;
        while (outstanding && t < 200) begin tick(); t++; end
        check("drain", outstanding, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
